// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR conversion controller.
package sar_pkg;

    // Controller states, in conversion order.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_COMP   = 3'd2,
        ST_RST    = 3'd3,
        ST_DONE   = 3'd4
    } sar_state_e;

    // Default geometry of the converter.
    localparam int unsigned SAR_N_BITS_DEF        = 8;
    localparam int unsigned SAR_SAMPLE_CYCLES_DEF = 2;
    localparam int unsigned SAR_TIMEOUT_DEF       = 15;

    // Width of a counter that must be able to hold max_val.
    function automatic int unsigned sar_cnt_w(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    // Timeout counter width for the default timeout.
    localparam int unsigned SAR_TMO_W_DEF = sar_cnt_w(SAR_TIMEOUT_DEF);

endpackage

// File: rtl/sar_sync.sv
// Two-flop synchroniser for one asynchronous comparator output.
module sar_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sar_logic.sv
// Successive-approximation controller: samples, drives the comparator clock,
// binary-searches the DAC code and reports the result with a valid strobe.
module sar_logic
    import sar_pkg::*;
#(
    parameter int unsigned N_BITS        = SAR_N_BITS_DEF,
    parameter int unsigned SAMPLE_CYCLES = SAR_SAMPLE_CYCLES_DEF,
    parameter int unsigned TIMEOUT       = SAR_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dout_p,
    input  logic              dout_n,
    output logic              comp_clk,
    output logic              sample,
    output logic [N_BITS-1:0] dac_code,
    output logic [N_BITS-1:0] result,
    output logic              valid,
    output logic              busy,
    output logic              err_meta
);

    localparam int unsigned TMO_W = sar_cnt_w(TIMEOUT);
    localparam int unsigned SMP_W = sar_cnt_w(SAMPLE_CYCLES);
    localparam int unsigned IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(N_BITS - 1);

    sar_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  idx_m1;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [SMP_W-1:0]  smp_q, smp_d;
    logic [N_BITS-1:0] dac_q, dac_d;
    logic [N_BITS-1:0] result_q, result_d;
    logic              err_q, err_d;
    logic              comp_clk_q, comp_clk_d;
    logic              sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic              sync_p;
    logic              sync_n;
    logic              dec_keep;
    logic              dec_illegal;
    logic              quiet;
    logic              tmo_hit;

    // Comparator outputs are asynchronous; only synchronised copies reach the FSM.
    sar_sync u_sync_p (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dout_p),
        .q_o   (sync_p)
    );

    sar_sync u_sync_n (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dout_n),
        .q_o   (sync_n)
    );

    // Decode of the synchronised comparator pair and the timeout condition.
    assign dec_keep    = sync_p & ~sync_n;
    assign dec_illegal = sync_p & sync_n;
    assign quiet       = ~sync_p & ~sync_n;
    assign tmo_hit     = (tmo_q == TMO_LAST);
    assign idx_m1      = idx_q - IDX_W'(1);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dac_d    = dac_q;
        result_d = result_q;
        err_d    = err_q;
        tmo_d    = tmo_q + TMO_W'(1);
        smp_d    = smp_q + SMP_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (smp_q == SMP_LAST) begin
                    dac_d             = '0;
                    dac_d[N_BITS-1]   = 1'b1;
                    idx_d             = IDX_MSB;
                    state_d           = ST_COMP;
                end
            end

            ST_COMP: begin
                // A stuck comparator resolves as 0 once the timeout expires.
                if (!quiet || tmo_hit) begin
                    dac_d[idx_q] = dec_keep;
                    if (dec_illegal || quiet) begin
                        err_d = 1'b1;
                    end
                    if (idx_q != '0) begin
                        dac_d[idx_m1] = 1'b1;
                    end
                    state_d = ST_RST;
                end
            end

            ST_RST: begin
                // Wait for the comparator to precharge before the next evaluation.
                if (quiet || tmo_hit) begin
                    if (!quiet) begin
                        err_d = 1'b1;
                    end
                    if (idx_q != '0) begin
                        idx_d   = idx_m1;
                        state_d = ST_COMP;
                    end else begin
                        result_d = dac_q;
                        state_d  = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Both phase counters restart on every state entry.
        if (state_d != state_q) begin
            tmo_d = '0;
            smp_d = '0;
        end

        comp_clk_d = (state_d == ST_COMP);
        sample_d   = (state_d == ST_SAMPLE);
        valid_d    = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any conversion in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tmo_q      <= '0;
            smp_q      <= '0;
            dac_q      <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            comp_clk_q <= 1'b0;
            sample_q   <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            smp_q      <= smp_d;
            dac_q      <= dac_d;
            result_q   <= result_d;
            err_q      <= err_d;
            comp_clk_q <= comp_clk_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign comp_clk = comp_clk_q;
    assign sample   = sample_q;
    assign dac_code = dac_q;
    assign result   = result_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign err_meta = err_q;

endmodule

// File: tb/tb_sar_logic.sv
// Scoreboard bench for sar_logic with a behavioural comparator model.
module tb_sar_logic;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       dout_p;
    logic       dout_n;
    logic       comp_clk;
    logic       sample;
    logic [7:0] dac_code;
    logic [7:0] result;
    logic       valid;
    logic       busy;
    logic       err_meta;

    // Comparator model controls: 0 ideal, 1 stuck low, 2 both high (at fault_bit).
    logic [7:0] vin;
    int         fault_mode;
    int         fault_bit;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [7:0] res;
        logic       err;
        int         t0;
        int         lat;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] trial_q[$];
    logic       comp_clk_prev = 1'b0;

    sar_logic dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dout_p   (dout_p),
        .dout_n   (dout_n),
        .comp_clk (comp_clk),
        .sample   (sample),
        .dac_code (dac_code),
        .result   (result),
        .valid    (valid),
        .busy     (busy),
        .err_meta (err_meta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int lsb_idx(input logic [7:0] c);
        for (int i = 0; i < 8; i++) begin
            if (c[i]) return i;
        end
        return 8;
    endfunction

    // Zero-delay comparator: evaluates while comp_clk is high, precharged low otherwise.
    always_comb begin
        dout_p = 1'b0;
        dout_n = 1'b0;
        if (comp_clk) begin
            if (fault_mode == 1 && lsb_idx(dac_code) == fault_bit) begin
                dout_p = 1'b0;
                dout_n = 1'b0;
            end else if (fault_mode == 2 && lsb_idx(dac_code) == fault_bit) begin
                dout_p = 1'b1;
                dout_n = 1'b1;
            end else begin
                dout_p = (vin >= dac_code);
                dout_n = ~(vin >= dac_code);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks DAC trials on each comparator evaluation and results on valid.
    always @(posedge clk) begin
        #1;
        if (comp_clk && !comp_clk_prev && trial_q.size() > 0) begin
            logic [7:0] t;
            t = trial_q.pop_front();
            chk("dac_trial", 32'(dac_code), 32'(t));
        end
        comp_clk_prev = comp_clk;
        if (valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got result 0x%0h expected no valid", result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("err_meta", 32'(err_meta), 32'(e.err));
                chk("busy_in_done", 32'(busy), 32'd1);
                chk("dac_hold", 32'(dac_code), 32'(e.res));
                if (e.lat != 0) begin
                    chk("latency", 32'(edge_cnt - e.t0), 32'(e.lat));
                end
            end
        end
    end

    // Queue the expected outcome, pulse start, check the acceptance cycle.
    task automatic issue(input logic [7:0] v, input int fm, input int fb,
                         input logic [7:0] exp_res, input logic exp_err, input int lat);
        vin        = v;
        fault_mode = fm;
        fault_bit  = fb;
        sb_q.push_back('{res: exp_res, err: exp_err, t0: edge_cnt, lat: lat});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_sample", 32'(sample), 32'd1);
        chk("accept_err_clear", 32'(err_meta), 32'd0);
    endtask

    task automatic wait_valid(output int e);
        int n;
        n = 0;
        while (!valid && n < 200) begin
            tick();
            n++;
        end
        if (!valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_valid: got no valid after %0d cycles expected valid", n);
        end
        e = edge_cnt;
    endtask

    task automatic convert(input logic [7:0] v, input int fm, input int fb,
                           input logic [7:0] exp_res, input logic exp_err, input int lat);
        int e;
        issue(v, fm, fb, exp_res, exp_err, lat);
        wait_valid(e);
        tick();
    endtask

    initial begin
        int e1, e2, e3, n;
        rst_n      = 1'b0;
        start      = 1'b0;
        vin        = 8'h00;
        fault_mode = 0;
        fault_bit  = 0;
        repeat (3) tick();
        chk("reset_outputs", 32'({comp_clk, sample, dac_code, result, valid, busy, err_meta}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Ideal comparator with the full trial sequence.
        trial_q = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        convert(8'hA5, 0, 0, 8'hA5, 1'b0, 51);
        chk("trials_consumed", 32'(trial_q.size()), 32'd0);

        convert(8'hFF, 0, 0, 8'hFF, 1'b0, 51);

        // Zero input, with start pulses while busy and in the DONE cycle.
        issue(8'h00, 0, 0, 8'h00, 1'b0, 51);
        repeat (10) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (15) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(e1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_done_ignored", 32'(busy), 32'd0);
        repeat (60) tick();

        // Stuck comparator at bit 5: 15-cycle COMP timeout, 1-cycle RST.
        convert(8'hFF, 1, 5, 8'hDF, 1'b1, 61);
        chk("err_sticky_idle", 32'(err_meta), 32'd1);

        // Illegal decision at bit 7.
        convert(8'hA5, 2, 7, 8'h7F, 1'b1, 51);

        // Reset during bit 3: no valid expected for the aborted conversion.
        vin        = 8'h5A;
        fault_mode = 0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!(comp_clk && lsb_idx(dac_code) == 3) && n < 100) begin
            tick();
            n++;
        end
        chk("reach_bit3", 32'(comp_clk && lsb_idx(dac_code) == 3), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midreset_outputs", 32'({comp_clk, sample, dac_code, result, valid, busy, err_meta}), 32'd0);
        repeat (60) tick();
        convert(8'h3C, 0, 0, 8'h3C, 1'b0, 51);

        // Start held high: one conversion every 52 cycles.
        vin = 8'h3C;
        sb_q.push_back('{res: 8'h3C, err: 1'b0, t0: edge_cnt, lat: 51});
        sb_q.push_back('{res: 8'h3C, err: 1'b0, t0: 0, lat: 0});
        sb_q.push_back('{res: 8'h3C, err: 1'b0, t0: 0, lat: 0});
        start = 1'b1;
        wait_valid(e1);
        tick();
        wait_valid(e2);
        tick();
        wait_valid(e3);
        start = 1'b0;
        chk("held_gap1", 32'(e2 - e1), 32'd52);
        chk("held_gap2", 32'(e3 - e2), 32'd52);
        repeat (2) tick();
        chk("held_release_idle", 32'(busy), 32'd0);
        repeat (60) tick();

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
